// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op encodings driven on the op port
//   - FSM state type
//   - default operand width and iteration-counter width helper
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned MDU_CNT_W = $clog2(MDU_WIDTH + 1);

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } mdu_state_e;

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between execute-stage control and the MDU.
//   master: drives start, op, a, b (and mthi/mtlo), observes results
//   slave : the MDU itself
// mthi/mtlo exist only when MDU_HILO_WRITE_EN is defined.
interface mdu_if
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef MDU_HILO_WRITE_EN
    logic             mthi;
    logic             mtlo;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
`ifdef MDU_HILO_WRITE_EN
        output mthi, mtlo,
`endif
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
`ifdef MDU_HILO_WRITE_EN
        input  mthi, mtlo,
`endif
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_abs.sv
// mdu_abs: combinational two's-complement conditional negate.
//   din  in  WIDTH  value
//   neg  in  1      negate when high
//   dout out WIDTH  neg ? -din : din
module mdu_abs #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);
    assign dout = neg ? (~din + WIDTH'(1)) : din;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO, WIDTH+1 cycle
// latency (1 cycle for divide by zero).
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/op/a/b in; busy/done/div_zero/hi/lo out
// Optional MDU_HILO_WRITE_EN: mthi/mtlo write a into HI/LO while idle.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = MDU_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    mdu_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    mdu_state_e       state, state_d;
    mdu_op_e          op_q;
    logic             sign_a_q, sign_b_q, dz_q;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_hi, p_lo, opnd;
    logic             accept, finish;

    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, div_zero_q;

    // Operand magnitudes; signs only matter for the signed ops (op[0]).
    logic             neg_a, neg_b, is_div, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign neg_a  = bus.op[0] & bus.a[WIDTH-1];
    assign neg_b  = bus.op[0] & bus.b[WIDTH-1];
    assign is_div = bus.op[1];
    assign b_zero = (bus.b == '0);

    mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.din(bus.a), .neg(neg_a), .dout(a_mag));
    mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.din(bus.b), .neg(neg_b), .dout(b_mag));

    // Shared datapath: p_hi is product-high / partial remainder, p_lo is
    // multiplier / dividend shifting out while the quotient shifts in.
    logic [WIDTH:0] add_sum, div_shift, div_diff;

    assign add_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};

    // Result sign fix-up.
    logic                 prod_neg, quot_neg, rem_neg;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign prod_neg = (op_q == MDU_MULT) && (sign_a_q ^ sign_b_q);
    assign quot_neg = (op_q == MDU_DIV) && (sign_a_q ^ sign_b_q);
    assign rem_neg  = (op_q == MDU_DIV) && sign_a_q;

    mdu_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.din({p_hi, p_lo}), .neg(prod_neg), .dout(prod_fix));
    mdu_abs #(.WIDTH(WIDTH))   u_fix_quot (.din(p_lo), .neg(quot_neg), .dout(quot_fix));
    mdu_abs #(.WIDTH(WIDTH))   u_fix_rem  (.din(p_hi), .neg(rem_neg),  .dout(rem_fix));

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = (is_div && b_zero) ? FINISH : CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_W'(WIDTH - 1)) state_d = FINISH;
            end
            FINISH: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture and iteration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MDU_MULTU;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            cnt      <= '0;
            p_hi     <= '0;
            p_lo     <= '0;
            opnd     <= '0;
        end else if (accept) begin
            op_q     <= mdu_op_e'(bus.op);
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            dz_q     <= is_div & b_zero;
            cnt      <= '0;
            if (is_div && b_zero) begin
                p_hi <= bus.a;
                p_lo <= '1;
            end else if (is_div) begin
                p_hi <= '0;
                p_lo <= a_mag;
                opnd <= b_mag;
            end else begin
                p_hi <= '0;
                p_lo <= b_mag;
                opnd <= a_mag;
            end
        end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
            if (op_q[1]) begin
                // Restore by keeping the shifted value when the trial subtract borrows.
                p_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                p_lo <= {p_lo[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                {p_hi, p_lo} <= {add_sum, p_lo[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                if (dz_q) begin
                    hi_q       <= p_hi;
                    lo_q       <= p_lo;
                    div_zero_q <= 1'b1;
                end else if (op_q[1]) begin
                    hi_q       <= rem_fix;
                    lo_q       <= quot_fix;
                    div_zero_q <= 1'b0;
                end else begin
                    {hi_q, lo_q} <= prod_fix;
                    div_zero_q   <= 1'b0;
                end
            end
`ifdef MDU_HILO_WRITE_EN
            else if (state == IDLE && !bus.start) begin
                if (bus.mthi) hi_q <= bus.a;
                if (bus.mtlo) lo_q <= bus.a;
            end
`endif
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit in the execute stage, next to the ALU. It takes the same a/b operands the ALU receives and implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers. Control logic starts it with a single-cycle pulse and stalls on busy. HI/LO results feed the writeback mux on MFHI/MFLO.

## Interface
- WIDTH, 32, operand and result width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request, sampled only in IDLE
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  multiplicand / dividend (same source as ALU a)
- b  in  WIDTH  multiplier / divisor (same source as ALU b)
- mthi, mtlo  in  1  write a into HI/LO (only with MDU_HILO_WRITE_EN)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO are updated by an operation
- div_zero  out  1  sticky: last divide had b==0
- hi  out  WIDTH  HI register (product high / remainder)
- lo  out  WIDTH  LO register (product low / quotient)

## Operation
- States:
  - IDLE: if start, capture |a|, |b|, sign bits and op; go to CALC; busy=1.
  - CALC: one iteration per cycle for WIDTH cycles, counted by a cycle counter; then go to FINISH.
  - FINISH: apply sign fix-up, write HI/LO, done=1, busy=0; go to IDLE.
- Divide with b==0: IDLE goes straight to FINISH. Result: hi=a, lo={WIDTH{1}}, div_zero=1.
- Any other operation clears div_zero at FINISH.
- Multiply:
  - Shift-add on magnitudes; 2*WIDTH-bit product gives {hi,lo}.
  - MULT negates the product if sign_a^sign_b.
  - MULTU treats operands as unsigned.
- Divide:
  - Restoring divide on magnitudes; lo=quotient, hi=remainder.
  - DIV truncates toward zero: quotient negative if sign_a^sign_b; remainder takes sign of a.
  - DIV 0x80000000 / -1 gives lo=0x80000000, hi=0. No trap.
- start while busy is ignored (no queueing). Operands are not re-sampled after capture.
- HI/LO hold their value across idle cycles and change only at FINISH (or at mthi/mtlo).
- Reset values: busy=0, done=0, div_zero=0, hi=0, lo=0, state IDLE, counter 0.
- rst_n low mid-operation aborts immediately and asynchronously to the reset values. No done pulse is produced for the aborted operation.

## Timing
- Edge E0 samples start: busy=1 after E0.
- Normal operation:
  - Iterations occur on E1..E(WIDTH); state is FINISH after E(WIDTH).
  - At E(WIDTH+1): hi/lo updated, done=1, busy=0.
  - Latency is WIDTH+1 cycles, i.e. 33 at default.
- Divide by zero: results and done after E1 (latency 1).
- done is high for exactly one cycle. start asserted during that cycle is accepted, giving back-to-back operation with no bubble.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- MDU_HILO_WRITE_EN defined:
  - Ports mthi/mtlo exist.
  - In IDLE with start low, mthi/mtlo write a into HI/LO at the next edge. Both may assert together.
  - Ignored while busy. start has priority over mthi/mtlo in the same cycle.
  - done is not pulsed by these writes.
- Not defined: ports absent; HI/LO written only by operations.

## Structure
- Package mdu_pkg:
  - op encodings (MDU_MULTU, MDU_MULT, MDU_DIVU, MDU_DIV)
  - state enum (IDLE, CALC, FINISH)
  - WIDTH default and counter width $clog2(WIDTH+1)
- One sub-module: mdu_abs, a combinational two's-complement conditional negate. It is used for operand magnitude and for result sign fix-up.

## Test plan
- MULTU a=0x00FF00FF b=0x00FF0001 -> after 33 cycles done=1, hi=0x0000FE01, lo=0xFF0000FF, busy falls with done.
- MULT a=0xFFFFFFFE b=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU a=0x00001234 b=0 -> done one cycle after start, div_zero=1, hi=0x00001234, lo=0xFFFFFFFF. A following MULTU clears div_zero.
- Control sequence, checked in order:
  - start pulsed again at cycle 5 of a MULTU: ignored, result unchanged.
  - rst_n low at cycle 10 of a new operation: busy/done/hi/lo=0 immediately.
  - start on the done cycle of a run: accepted.
- With MDU_HILO_WRITE_EN:
  - mthi a=0xA5A5A5A5 while idle -> hi=0xA5A5A5A5 next edge, no done.
  - mtlo while busy -> lo unchanged.
